host_port_mux: RTL and testbench

Parametrised N-port host arbiter between the physical host links (UARTs, I2C FSM) and the single `spi_bootloader` byte-stream interface. A magic byte on a magic-capable port locks that port as the sole host and drives its TX pin enable. While nothing is locked, a designated default port is routed. Lock release happens on break or idle timeout, and every ownership change issues a one-cycle bootloader reset pulse.

---
 rtl/host_port_mux_pkg.sv | 16 +
 rtl/host_port_mux_if.sv | 37 +++
 rtl/host_port_mux_idle_timer.sv | 41 ++++
 rtl/host_port_mux.sv | 128 ++++++++++++
 tb/tb_host_port_mux.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/host_port_mux_pkg.sv
// host_port_mux shared definitions
// lock state encoding, default magic byte, one-hot helper
package host_port_mux_pkg;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   localparam logic [7:0] MAGIC_BYTE_DEFAULT = 8'hbc;

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'b1 << idx;
   endfunction

endpackage

// File: rtl/host_port_mux_if.sv
// host_port_mux stream bundle
// per-port host links plus both bootloader streams
interface host_port_mux_if #(
   parameter int N = 3,
   parameter int W = 8
);
   logic [N-1:0]   port_rx_valid;
   logic [N*W-1:0] port_rx_data;
   logic [N-1:0]   port_rx_ready;
   logic [N-1:0]   port_rx_break;
   logic [N-1:0]   port_tx_valid;
   logic [W-1:0]   port_tx_data;
   logic [N-1:0]   port_tx_ready;
   logic           bl_in_valid;
   logic [W-1:0]   bl_in_data;
   logic           bl_in_ready;
   logic           bl_out_valid;
   logic [W-1:0]   bl_out_data;
   logic           bl_out_ready;

   modport slave (
      input  port_rx_valid, port_rx_data, port_rx_break,
      input  port_tx_ready, bl_in_ready,
      input  bl_out_valid, bl_out_data,
      output port_rx_ready, port_tx_valid, port_tx_data,
      output bl_in_valid, bl_in_data, bl_out_ready
   );

   modport master (
      output port_rx_valid, port_rx_data, port_rx_break,
      output port_tx_ready, bl_in_ready,
      output bl_out_valid, bl_out_data,
      input  port_rx_ready, port_tx_valid, port_tx_data,
      input  bl_in_valid, bl_in_data, bl_out_ready
   );

endinterface

// File: rtl/host_port_mux_idle_timer.sv
// idle_timer: saturating inactivity counter
// expired fires during the TIMEOUT-th consecutive enabled cycle
module idle_timer #(
   parameter int TIMEOUT = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   if (TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, reset_n, enable, clear};
      assign expired   = 1'b0;
   end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      // count idle cycles, hold at TIMEOUT instead of wrapping
      always_comb begin
         cnt_d = cnt_q;
         if (clear)
            cnt_d = '0;
         else if (enable && cnt_q != CW'(TIMEOUT))
            cnt_d = cnt_q + 1'b1;
      end

      // counter register
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            cnt_q <= '0;
         else
            cnt_q <= cnt_d;
      end

      assign expired = enable && (cnt_q >= CW'(TIMEOUT - 1));
   end

endmodule

// File: rtl/host_port_mux.sv
// host_port_mux: N-port host arbiter in front of the bootloader
// magic byte locks a port; break/idle release; ownership change resets bootloader
module host_port_mux
   import host_port_mux_pkg::*;
#(
   parameter int                        NUM_PORTS        = 3,
   parameter int                        DATA_WIDTH       = 8,
   parameter logic [DATA_WIDTH-1:0]     MAGIC_BYTE       = MAGIC_BYTE_DEFAULT,
   parameter logic [NUM_PORTS-1:0]      MAGIC_MASK       = 3'b011,
   parameter int                        DEFAULT_PORT     = 2,
   parameter bit                        RELEASE_ON_BREAK = 1'b1,
   parameter int                        IDLE_TIMEOUT     = 0,
   localparam int                       SW = $clog2(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ext_reset,
   host_port_mux_if.slave       bus,
   output logic [NUM_PORTS-1:0] port_tx_enable,
   output logic                 bl_reset,
   output logic                 locked,
   output logic [SW-1:0]        active_port
);

   localparam logic [SW-1:0] DEF_SEL = SW'(DEFAULT_PORT);
   localparam logic [NUM_PORTS-1:0] TX_EN_RST =
      NUM_PORTS'(onehot8(3'(DEFAULT_PORT)));

   lock_state_e            state_q, state_d;
   logic [SW-1:0]          sel_q, sel_d;
   logic                   bl_reset_q, bl_reset_d;
   logic [NUM_PORTS-1:0]   tx_en_q, tx_en_d;

   logic                   magic_hit;
   logic [SW-1:0]          magic_port;
   logic                   is_locked, brk, rx_hs, tx_hs;
   logic                   timer_en, timer_clr, expired, release_lk;

   assign is_locked = (state_q == LOCKED);

   // route the selected port to the bootloader, drain the others
   always_comb begin
      bus.port_rx_ready = '1;
      bus.port_tx_valid = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (SW'(i) == sel_q) begin
            bus.port_rx_ready[i] = bus.bl_in_ready;
            bus.port_tx_valid[i] = bus.bl_out_valid;
         end
      end
   end

   assign bus.bl_in_valid  = bus.port_rx_valid[sel_q];
   assign bus.bl_in_data   =
      bus.port_rx_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
   assign bus.port_tx_data = bus.bl_out_data;
   assign bus.bl_out_ready = bus.port_tx_ready[sel_q];

   // lowest-index magic-capable port presenting the magic byte
   always_comb begin
      magic_hit  = 1'b0;
      magic_port = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (MAGIC_MASK[i] && bus.port_rx_valid[i] &&
             bus.port_rx_data[i*DATA_WIDTH +: DATA_WIDTH] == MAGIC_BYTE) begin
            magic_hit  = 1'b1;
            magic_port = SW'(i);
         end
      end
   end

   assign rx_hs     = bus.bl_in_valid && bus.bl_in_ready;
   assign tx_hs     = bus.bl_out_valid && bus.bl_out_ready;
   assign brk       = is_locked && bus.port_rx_break[sel_q];
   assign timer_en  = is_locked && !rx_hs && !tx_hs;
   assign timer_clr = !is_locked || rx_hs || tx_hs;

   idle_timer #(
      .TIMEOUT (IDLE_TIMEOUT)
   ) u_idle (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (timer_en),
      .clear   (timer_clr),
      .expired (expired)
   );

   assign release_lk = (brk && RELEASE_ON_BREAK) || expired;

   // lock/release decision; release wins, re-lock waits a cycle
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      bl_reset_d = ext_reset || brk || expired;
      if (is_locked) begin
         if (release_lk) begin
            state_d = UNLOCKED;
            sel_d   = DEF_SEL;
         end
      end else if (magic_hit) begin
         state_d    = LOCKED;
         sel_d      = magic_port;
         bl_reset_d = 1'b1;
      end
      tx_en_d = NUM_PORTS'(onehot8(3'(sel_d)));
   end

   // ownership state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= UNLOCKED;
         sel_q      <= DEF_SEL;
         bl_reset_q <= 1'b0;
         tx_en_q    <= TX_EN_RST;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         bl_reset_q <= bl_reset_d;
         tx_en_q    <= tx_en_d;
      end
   end

   assign port_tx_enable = tx_en_q;
   assign bl_reset       = bl_reset_q;
   assign locked         = is_locked;
   assign active_port    = sel_q;

endmodule

// File: tb/tb_host_port_mux.sv
// tb_host_port_mux: directed scenarios plus random traffic
// checked every cycle against a behavioural ownership model
module tb_host_port_mux;

   localparam int N  = 3;
   localparam int W  = 8;
   localparam int TO = 100;
   localparam int DEF = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ext_reset = 1'b0;
   logic [N-1:0] tx_en;
   logic bl_reset, locked;
   logic [1:0] active;

   int total = 0;
   int bad = 0;

   int m_locked, m_own, m_rst, m_idle;

   always #5 clk = ~clk;

   host_port_mux_if #(.N(N), .W(W)) bus ();

   host_port_mux #(
      .NUM_PORTS        (N),
      .DATA_WIDTH       (W),
      .MAGIC_BYTE       (8'hbc),
      .MAGIC_MASK       (3'b011),
      .DEFAULT_PORT     (DEF),
      .RELEASE_ON_BREAK (1'b1),
      .IDLE_TIMEOUT     (TO)
   ) dut (
      .clk            (clk),
      .reset_n        (rst_n),
      .ext_reset      (ext_reset),
      .bus            (bus),
      .port_tx_enable (tx_en),
      .bl_reset       (bl_reset),
      .locked         (locked),
      .active_port    (active)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.port_rx_valid = '0;
      bus.port_rx_break = '0;
      bus.bl_out_valid  = 1'b0;
      ext_reset         = 1'b0;
   endtask

   function automatic logic [7:0] rx_byte(input int p);
      logic [N*W-1:0] d;
      d = bus.port_rx_data;
      return d[p*W +: W];
   endfunction

   // per-cycle reference: expected outputs, then advance the model
   always @(negedge clk) begin : model_p
      int sel, win;
      bit rxhs, txhs, brk, tmo;
      logic [N-1:0] exp_rdy;
      if (!rst_n) begin
         m_locked = 0;
         m_own    = DEF;
         m_rst    = 0;
         m_idle   = 0;
      end else begin
         sel = m_locked ? m_own : DEF;
         exp_rdy = '1;
         exp_rdy[sel] = bus.bl_in_ready;
         chk("locked", locked, m_locked);
         chk("active_port", active, sel);
         chk("tx_enable", tx_en, 1 << sel);
         chk("bl_reset", bl_reset, m_rst);
         chk("bl_in_valid", bus.bl_in_valid, bus.port_rx_valid[sel]);
         chk("bl_in_data", bus.bl_in_data, rx_byte(sel));
         chk("rx_ready", bus.port_rx_ready, exp_rdy);
         chk("tx_valid", bus.port_tx_valid,
             bus.bl_out_valid ? (1 << sel) : 0);
         chk("tx_data", bus.port_tx_data, bus.bl_out_data);
         chk("bl_out_ready", bus.bl_out_ready, bus.port_tx_ready[sel]);

         rxhs = bus.port_rx_valid[sel] && bus.bl_in_ready;
         txhs = bus.bl_out_valid && bus.port_tx_ready[sel];
         if (m_locked != 0) begin
            m_idle = (rxhs || txhs) ? 0 : m_idle + 1;
            brk    = bus.port_rx_break[m_own];
            tmo    = (m_idle >= TO);
            m_rst  = int'(brk || tmo || ext_reset);
            if (brk || tmo) begin
               m_locked = 0;
               m_own    = DEF;
               m_idle   = 0;
            end
         end else begin
            win = -1;
            for (int i = 0; i < 2; i++)
               if (win < 0 && bus.port_rx_valid[i] && rx_byte(i) == 8'hbc)
                  win = i;
            m_rst = int'(win >= 0 || ext_reset);
            if (win >= 0) begin
               m_locked = 1;
               m_own    = win;
               m_idle   = 0;
            end
         end
      end
   end

   initial begin
      logic [N*W-1:0] d;
      idle_inputs();
      bus.port_rx_data  = '0;
      bus.bl_out_data   = '0;
      bus.bl_in_ready   = 1'b1;
      bus.port_tx_ready = '1;
      repeat (3) tick();
      rst_n = 1'b1;

      // reset state
      chk("rst_active", active, 2);
      chk("rst_tx_en", tx_en, 3'b100);
      chk("rst_locked", locked, 0);
      chk("rst_bl_reset", bl_reset, 0);

      // default port forwards, others drained
      bus.port_rx_valid = 3'b111;
      bus.port_rx_data  = {8'h55, 8'h22, 8'h11};
      bus.bl_in_ready   = 1'b0;
      #1;
      chk("def_valid", bus.bl_in_valid, 1);
      chk("def_data", bus.bl_in_data, 8'h55);
      chk("def_rx_ready", bus.port_rx_ready, 3'b011);
      tick();

      // simultaneous magic on 0 and 1: port 0 wins, nothing forwarded
      bus.bl_in_ready   = 1'b1;
      bus.port_rx_valid = 3'b011;
      bus.port_rx_data  = {8'h00, 8'hbc, 8'hbc};
      #1;
      chk("magic_not_fwd", bus.bl_in_valid, 0);
      tick();
      idle_inputs();
      chk("lock_locked", locked, 1);
      chk("lock_active", active, 0);
      chk("lock_tx_en", tx_en, 3'b001);
      chk("lock_pulse", bl_reset, 1);
      tick();
      chk("lock_pulse_end", bl_reset, 0);

      // locked: magic byte is ordinary data
      bus.port_rx_valid = 3'b011;
      #1;
      chk("locked_fwd_data", bus.bl_in_data, 8'hbc);
      tick();
      idle_inputs();
      chk("locked_stays", active, 0);

      // idle timeout, restarted by a byte in idle cycle 99
      repeat (98) tick();
      bus.port_rx_valid = 3'b001;
      bus.port_rx_data  = {8'h00, 8'h00, 8'h33};
      tick();
      idle_inputs();
      repeat (99) tick();
      chk("idle_99_locked", locked, 1);
      tick();
      chk("idle_release", locked, 0);
      chk("idle_pulse", bl_reset, 1);
      chk("idle_active", active, 2);
      tick();
      chk("idle_pulse_end", bl_reset, 0);

      // lock port 1, then break coincident with ext_reset
      bus.port_rx_valid = 3'b010;
      bus.port_rx_data  = {8'h00, 8'hbc, 8'h00};
      tick();
      idle_inputs();
      chk("lock1_active", active, 1);
      tick();
      bus.port_rx_break = 3'b010;
      ext_reset = 1'b1;
      tick();
      idle_inputs();
      chk("brk_release", locked, 0);
      chk("brk_pulse", bl_reset, 1);
      tick();
      chk("brk_pulse_once", bl_reset, 0);

      // async reset while locked with TX in flight
      bus.port_rx_valid = 3'b001;
      bus.port_rx_data  = {8'h00, 8'h00, 8'hbc};
      tick();
      idle_inputs();
      bus.bl_out_valid  = 1'b1;
      bus.port_tx_ready = '1;
      #1;
      chk("pre_rst_txv", bus.port_tx_valid, 3'b001);
      rst_n = 1'b0;
      #1;
      chk("arst_locked", locked, 0);
      chk("arst_active", active, 2);
      chk("arst_tx_en", tx_en, 3'b100);
      chk("arst_bl_reset", bl_reset, 0);
      chk("arst_txv", bus.port_tx_valid, 3'b100);
      tick();
      rst_n = 1'b1;

      // random traffic with quiet windows long enough to time out
      for (int c = 0; c < 4000; c++) begin
         if ((c % 400) >= 250) begin
            idle_inputs();
         end else begin
            bus.port_rx_valid = N'($urandom);
            for (int p = 0; p < N; p++)
               d[p*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hbc
                                                         : 8'($urandom);
            bus.port_rx_data = d;
            for (int p = 0; p < N; p++)
               bus.port_rx_break[p] = ($urandom_range(0, 39) == 0);
            bus.bl_out_valid = 1'($urandom);
            bus.bl_out_data  = 8'($urandom);
            ext_reset = ($urandom_range(0, 59) == 0);
         end
         bus.bl_in_ready   = ($urandom_range(0, 3) != 0);
         bus.port_tx_ready = N'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
